// File: rtl/mp64_uart_txarb.sv
// Round-robin scheduler sharing the UART MMIO port among N_REQ byte streams.
// Each byte waits for STATUS.tx_ready, and a grant is held until s_last.
module mp64_uart_txarb #(
   parameter int N_REQ        = 4,
   parameter int POLL_GAP     = 4,
   parameter int ACK_TIMEOUT  = 15,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   s_valid,
   input  logic [8*N_REQ-1:0] s_data,
   input  logic [N_REQ-1:0]   s_last,
   output logic [N_REQ-1:0]   s_ready,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               err,
   output logic               u_req,
   output logic [3:0]         u_addr,
   output logic [7:0]         u_wdata,
   output logic               u_wen,
   input  logic [7:0]         u_rdata,
   input  logic               u_ack
);
   localparam logic [3:0] UART_TX     = 4'h0;
   localparam logic [3:0] UART_STATUS = 4'h4;
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
   localparam int AW = $clog2(ACK_TIMEOUT + 1);
   localparam int LW = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_POLL_WAIT, S_GAP, S_WRITE, S_WRITE_WAIT, S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    g_q, g_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             last_q, last_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
   logic [LW-1:0]    lock_cnt_q, lock_cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             u_req_q, u_req_d;
   logic [3:0]       u_addr_q, u_addr_d;
   logic [7:0]       u_wdata_q, u_wdata_d;
   logic             u_wen_q, u_wen_d;

   logic [7:0]       s_byte [N_REQ];
   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic [IW-1:0]    rr_next;
   logic             release_grant;
   logic             rdata_unused;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign s_byte[gi] = s_data[8*gi +: 8];
   end

   // Only tx_ready is meaningful in the status word.
   assign rdata_unused = ^u_rdata[7:1];
   assign rr_next = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int          idx;
         logic [IW-1:0] idx_w;
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         idx_w = IW'(idx);
         if (!pick_found && s_valid[idx_w]) begin
            pick_found = 1'b1;
            pick_idx   = idx_w;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      g_d           = g_q;
      rr_ptr_d      = rr_ptr_q;
      last_d        = last_q;
      gap_cnt_d     = gap_cnt_q;
      ack_cnt_d     = ack_cnt_q;
      lock_cnt_d    = lock_cnt_q;
      err_d         = 1'b0;
      release_grant = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               g_d     = pick_idx;
               state_d = S_POLL;
            end
         end
         S_POLL: begin
            ack_cnt_d = AW'(1);
            state_d   = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            if (u_ack) begin
               if (u_rdata[0]) begin
                  state_d = S_WRITE;
               end else if (POLL_GAP == 0) begin
                  state_d = S_POLL;
               end else begin
                  gap_cnt_d = '0;
                  state_d   = S_GAP;
               end
            end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
               err_d         = 1'b1;
               release_grant = 1'b1;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GW'(POLL_GAP - 1)) state_d = S_POLL;
            else gap_cnt_d = gap_cnt_q + 1'b1;
         end
         S_WRITE: begin
            last_d    = s_last[g_q];
            ack_cnt_d = AW'(1);
            state_d   = S_WRITE_WAIT;
         end
         S_WRITE_WAIT: begin
            if (u_ack) begin
               if (last_q) begin
                  release_grant = 1'b1;
               end else if (s_valid[g_q]) begin
                  state_d = S_POLL;
               end else begin
                  lock_cnt_d = '0;
                  state_d    = S_HOLD;
               end
            end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
               err_d         = 1'b1;
               release_grant = 1'b1;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (s_valid[g_q]) state_d = S_POLL;
            else if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) release_grant = 1'b1;
            else lock_cnt_d = lock_cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (release_grant) begin
         state_d  = S_IDLE;
         rr_ptr_d = rr_next;
         last_d   = 1'b0;
      end

      // Outputs are registered images of the state being entered.
      grant_d = '0;
      if (state_d != S_IDLE) grant_d[g_d] = 1'b1;
      busy_d    = (state_d != S_IDLE);
      u_req_d   = (state_d == S_POLL) || (state_d == S_WRITE);
      u_wen_d   = (state_d == S_WRITE);
      u_addr_d  = (state_d == S_POLL) ? UART_STATUS : UART_TX;
      u_wdata_d = (state_d == S_WRITE) ? s_byte[g_d] : 8'h00;
      if (!u_req_d) u_addr_d = 4'h0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         g_q        <= '0;
         rr_ptr_q   <= '0;
         last_q     <= 1'b0;
         gap_cnt_q  <= '0;
         ack_cnt_q  <= '0;
         lock_cnt_q <= '0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         u_req_q    <= 1'b0;
         u_addr_q   <= 4'h0;
         u_wdata_q  <= 8'h00;
         u_wen_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         g_q        <= g_d;
         rr_ptr_q   <= rr_ptr_d;
         last_q     <= last_d;
         gap_cnt_q  <= gap_cnt_d;
         ack_cnt_q  <= ack_cnt_d;
         lock_cnt_q <= lock_cnt_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         u_req_q    <= u_req_d;
         u_addr_q   <= u_addr_d;
         u_wdata_q  <= u_wdata_d;
         u_wen_q    <= u_wen_d;
      end
   end

   assign s_ready = (state_q == S_WRITE) ? grant_q : '0;
   assign grant   = grant_q;
   assign busy    = busy_q;
   assign err     = err_q;
   assign u_req   = u_req_q;
   assign u_addr  = u_addr_q;
   assign u_wdata = u_wdata_q;
   assign u_wen   = u_wen_q;

endmodule

// File: tb/tb_mp64_uart_txarb.sv
// Bench for mp64_uart_txarb: directed timing scenarios plus randomized message
// rounds checked against a message-level round-robin reference model.
`timescale 1ns/1ps
module tb_mp64_uart_txarb;
   localparam int N        = 4;
   localparam int POLL_GAP = 4;
   localparam int ACK_TO   = 15;
   localparam int LOCK_TO  = 8;
   localparam logic [3:0] A_TX = 4'h0;
   localparam logic [3:0] A_ST = 4'h4;
   localparam int MAXC = 40000;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   s_valid;
   logic [8*N-1:0] s_data;
   logic [N-1:0]   s_last;
   logic [N-1:0]   s_ready;
   logic [N-1:0]   grant;
   logic           busy, err, u_req, u_wen, u_ack;
   logic [3:0]     u_addr;
   logic [7:0]     u_wdata, u_rdata;

   always #5 clk = ~clk;

   mp64_uart_txarb #(
      .N_REQ(N), .POLL_GAP(POLL_GAP), .ACK_TIMEOUT(ACK_TO), .LOCK_TIMEOUT(LOCK_TO)
   ) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .grant(grant), .busy(busy), .err(err), .u_req(u_req),
      .u_addr(u_addr), .u_wdata(u_wdata), .u_wen(u_wen), .u_rdata(u_rdata), .u_ack(u_ack)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int model_rr = 0;

   logic [8:0]  rq [N][$];     // stimulus: {last, byte}
   logic [8:0]  mq [N][$];     // copy consumed by the reference model
   bit          pop_pend [N];
   int          ack_cnt = 0;
   int          ack_lat_max = 1;
   logic [7:0]  ack_data = 8'h00;
   bit          withhold_wr = 1'b0;
   bit          st_rand = 1'b0;
   logic [7:0]  st_q [$];
   logic        prev_req = 1'b0;

   logic [11:0] wr_log [$];
   logic [11:0] exp_q  [$];
   int          wr_cyc [$];
   int          poll_cyc [$];
   int          sr_cyc [$];
   int          err_cyc [$];
   logic [N-1:0] grant_log [MAXC];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // UART responder, requester drivers and output monitor, stepping #1 after each edge.
   initial begin
      s_valid = '0; s_data = '0; s_last = '0; u_ack = 1'b0; u_rdata = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         u_ack = 1'b0;
         u_rdata = 8'h00;
         if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
               u_ack = 1'b1;
               u_rdata = ack_data;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (pop_pend[i]) begin
               if (rq[i].size() > 0) void'(rq[i].pop_front());
               pop_pend[i] = 1'b0;
            end
            s_valid[i] = (rq[i].size() > 0);
            s_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            s_last[i] = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
         end
         if (cyc < MAXC) grant_log[cyc] = grant;
         if (err) err_cyc.push_back(cyc);
         if (s_ready != '0) begin
            sr_cyc.push_back(cyc);
            check_val("s_ready_with_write", {29'b0, s_ready == grant, u_req, u_wen}, 32'h7);
            for (int i = 0; i < N; i++) if (s_ready[i]) pop_pend[i] = 1'b1;
         end
         if (u_req) begin
            check_val("u_req_pulse", {31'b0, prev_req}, 32'h0);
            if (!u_wen) begin
               logic [7:0] r;
               poll_cyc.push_back(cyc);
               check_val("poll_addr", {28'b0, u_addr}, {28'b0, A_ST});
               if (st_q.size() > 0) ack_data = st_q.pop_front();
               else if (st_rand) begin
                  r = 8'($urandom);
                  r[0] = ($urandom_range(0, 3) != 0);
                  ack_data = r;
               end else ack_data = 8'h01;
               ack_cnt = $urandom_range(1, ack_lat_max);
            end else begin
               int gi;
               logic [8:0] e;
               gi = -1;
               for (int i = 0; i < N; i++) if (grant[i]) gi = i;
               wr_log.push_back({grant, u_wdata});
               wr_cyc.push_back(cyc);
               $display("[TB] cyc %0d write grant=%b data=%02h", cyc, grant, u_wdata);
               check_val("wr_addr", {28'b0, u_addr}, {28'b0, A_TX});
               check_val("wr_grant_onehot", $countones(grant), 1);
               if (gi >= 0 && rq[gi].size() > 0) begin
                  e = rq[gi][0];
                  check_val("wr_data_presented", {24'b0, u_wdata}, {24'b0, e[7:0]});
               end
               ack_data = 8'h00;
               if (!withhold_wr) ack_cnt = $urandom_range(1, ack_lat_max);
            end
         end
         prev_req = u_req;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   function automatic bit all_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < N; i++) if (rq[i].size() > 0 || pop_pend[i]) e = 1'b0;
      return e;
   endfunction

   task automatic clear_logs();
      wr_log.delete(); wr_cyc.delete(); poll_cyc.delete(); sr_cyc.delete(); err_cyc.delete();
   endtask

   task automatic push_byte(input int i, input logic [7:0] b, input logic last);
      rq[i].push_back({last, b});
      mq[i].push_back({last, b});
   endtask

   task automatic push_rand_msg(input int i, input int len);
      for (int k = 0; k < len; k++) push_byte(i, 8'($urandom), k == len - 1);
   endtask

   // Reference: whole messages granted round-robin from model_rr.
   task automatic predict();
      int rr, pick;
      logic [8:0] e;
      logic [N-1:0] oh;
      rr = model_rr;
      exp_q.delete();
      while (1) begin
         pick = -1;
         for (int k = 0; k < N; k++) if (pick < 0 && mq[(rr + k) % N].size() > 0) pick = (rr + k) % N;
         if (pick < 0) break;
         oh = '0;
         oh[pick] = 1'b1;
         do begin
            e = mq[pick].pop_front();
            exp_q.push_back({oh, e[7:0]});
         end while (!e[8] && mq[pick].size() > 0);
         rr = (pick + 1) % N;
      end
      model_rr = rr;
   endtask

   task automatic run_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         wait_cyc(1);
         done = (busy == 1'b0) && all_empty();
      end
      check_val("idle_in_budget", {31'b0, done}, 32'h1);
   endtask

   task automatic wait_writes(input int cnt, input int budget);
      bit done;
      done = (wr_log.size() >= cnt);
      for (int n = 0; n < budget && !done; n++) begin
         wait_cyc(1);
         done = (wr_log.size() >= cnt);
      end
      check_val("writes_in_budget", {31'b0, done}, 32'h1);
   endtask

   task automatic compare_writes(input string tag);
      check_val({tag, "_count"}, wr_log.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
         check_val(tag, {20'b0, wr_log[k]}, {20'b0, exp_q[k]});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin
         rq[i].delete(); mq[i].delete(); pop_pend[i] = 1'b0;
      end
      ack_cnt = 0; withhold_wr = 1'b0; st_q.delete(); st_rand = 1'b0;
      ack_lat_max = 1; model_rr = 0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_grant", {28'b0, grant}, 0);
      check_val("rst_busy", {31'b0, busy}, 0);
      check_val("rst_err", {31'b0, err}, 0);
      check_val("rst_u_req", {31'b0, u_req}, 0);
      check_val("rst_u_addr", {28'b0, u_addr}, 0);
      check_val("rst_u_wdata", {24'b0, u_wdata}, 0);
      check_val("rst_u_wen", {31'b0, u_wen}, 0);
      check_val("rst_s_ready", {28'b0, s_ready}, 0);
      #1 rst = 1'b0;
      wait_cyc(1);
      clear_logs();
   endtask

   initial begin
      int t, w;
      logic [N-1:0] oh;
      do_reset();

      // Single requester, always-ready UART: 4 cycles per byte.
      push_byte(0, 8'h41, 1'b0);
      push_byte(0, 8'h42, 1'b1);
      t = cyc + 1;
      predict();
      run_idle(200);
      compare_writes("single_order");
      check_val("single_poll0_cyc", poll_cyc.size() > 0 ? poll_cyc[0] : -1, t + 1);
      check_val("single_wr0_cyc", wr_cyc.size() > 0 ? wr_cyc[0] : -1, t + 3);
      check_val("single_sr0_cyc", sr_cyc.size() > 0 ? sr_cyc[0] : -1, t + 3);
      check_val("single_poll1_cyc", poll_cyc.size() > 1 ? poll_cyc[1] : -1, t + 5);
      check_val("single_wr1_cyc", wr_cyc.size() > 1 ? wr_cyc[1] : -1, t + 7);
      check_val("single_grant_end", {28'b0, grant}, 0);

      // rr_ptr is now 1: requester 1 wins over 0.
      clear_logs();
      push_byte(0, 8'h10, 1'b1);
      push_byte(1, 8'h11, 1'b1);
      predict();
      run_idle(200);
      compare_writes("rr_after_single");

      // Move rr_ptr to 2, then two 2-byte messages each on requesters 1 and 3.
      clear_logs();
      push_byte(1, 8'h21, 1'b1);
      predict();
      run_idle(200);
      compare_writes("rr_to_two");
      clear_logs();
      for (int m = 0; m < 2; m++) begin
         push_byte(1, 8'h30 + 8'(m), 1'b0); push_byte(1, 8'h38 + 8'(m), 1'b1);
         push_byte(3, 8'h50 + 8'(m), 1'b0); push_byte(3, 8'h58 + 8'(m), 1'b1);
      end
      predict();
      run_idle(400);
      compare_writes("fair_order");
      check_val("fair_intra_msg_gap", wr_cyc.size() > 1 ? wr_cyc[1] - wr_cyc[0] : -1, 4);
      check_val("fair_rearb_gap", wr_cyc.size() > 2 ? wr_cyc[2] - wr_cyc[1] : -1, 5);

      // Not-ready polling: three busy status reads, then ready.
      clear_logs();
      st_q.push_back(8'h00); st_q.push_back(8'h00); st_q.push_back(8'h00); st_q.push_back(8'h01);
      push_byte(0, 8'h77, 1'b1);
      t = cyc + 1;
      predict();
      run_idle(300);
      compare_writes("poll_order");
      check_val("poll_count", poll_cyc.size(), 4);
      for (int k = 1; k < poll_cyc.size(); k++)
         check_val("poll_spacing", poll_cyc[k] - poll_cyc[k-1], POLL_GAP + 2);
      check_val("poll_first_cyc", poll_cyc.size() > 0 ? poll_cyc[0] : -1, t + 1);
      check_val("poll_wr_after_ready", wr_cyc.size() > 0 ? wr_cyc[0] : -1, t + 1 + 3 * (POLL_GAP + 2) + 2);
      check_val("poll_first_s_ready", sr_cyc.size() > 0 ? sr_cyc[0] : -1, wr_cyc.size() > 0 ? wr_cyc[0] : -2);

      // Lock hold: requester 2 goes quiet mid-message while requester 0 waits.
      clear_logs();
      for (int i = 0; i < N; i++) mq[i].delete();
      push_byte(2, 8'hA0, 1'b0);
      push_byte(0, 8'hB0, 1'b1);
      wait_writes(2, 300);
      w = wr_cyc.size() > 0 ? wr_cyc[0] : 0;
      check_val("lock_grant_held", {28'b0, grant_log[w + 1 + LOCK_TO]}, 32'h4);
      check_val("lock_grant_released", {28'b0, grant_log[w + 2 + LOCK_TO]}, 0);
      check_val("lock_next_poll", poll_cyc.size() > 1 ? poll_cyc[1] : -1, w + 3 + LOCK_TO);
      push_byte(2, 8'hA1, 1'b1);
      run_idle(300);
      exp_q.delete();
      exp_q.push_back({4'b0100, 8'hA0}); exp_q.push_back({4'b0001, 8'hB0}); exp_q.push_back({4'b0100, 8'hA1});
      compare_writes("lock_order");
      for (int i = 0; i < N; i++) mq[i].delete();
      model_rr = 3;

      // Ack withheld after a write: err 15 cycles after the u_req.
      clear_logs();
      withhold_wr = 1'b1;
      push_byte(3, 8'hC3, 1'b1);
      mq[3].delete();
      wait_writes(1, 200);
      w = wr_cyc.size() > 0 ? wr_cyc[0] : 0;
      wait_cyc(ACK_TO + 4);
      check_val("timeout_err_count", err_cyc.size(), 1);
      check_val("timeout_err_cyc", err_cyc.size() > 0 ? err_cyc[0] : -1, w + ACK_TO);
      check_val("timeout_grant_before", {28'b0, grant_log[w + ACK_TO - 1]}, 32'h8);
      check_val("timeout_grant_after", {28'b0, grant_log[w + ACK_TO]}, 0);
      check_val("timeout_busy", {31'b0, busy}, 0);
      withhold_wr = 1'b0;
      model_rr = 0;

      // Push rr_ptr to 3, then reset in WRITE_WAIT.
      clear_logs();
      push_byte(2, 8'hD2, 1'b1);
      predict();
      run_idle(200);
      compare_writes("pre_reset_order");
      clear_logs();
      withhold_wr = 1'b1;
      push_byte(0, 8'hE0, 1'b1);
      wait_writes(1, 200);
      wait_cyc(1);
      check_val("pre_rst_grant", {28'b0, grant}, 32'h1);
      rst = 1'b1;
      #1;
      check_val("async_rst_grant", {28'b0, grant}, 0);
      check_val("async_rst_busy", {31'b0, busy}, 0);
      check_val("async_rst_u_req", {31'b0, u_req}, 0);
      do_reset();
      push_byte(3, 8'hF3, 1'b1);
      push_byte(1, 8'hF1, 1'b1);
      predict();
      run_idle(200);
      compare_writes("post_rst_order");

      // Randomized rounds: random messages, random readiness and ack latency.
      st_rand = 1'b1;
      ack_lat_max = 3;
      for (int r = 0; r < 12; r++) begin
         clear_logs();
         for (int i = 0; i < N; i++) begin
            int nm;
            nm = $urandom_range(0, 2);
            for (int m = 0; m < nm; m++) push_rand_msg(i, $urandom_range(1, 3));
         end
         predict();
         run_idle(3000);
         compare_writes("rand_order");
         check_val("rand_no_err", err_cyc.size(), 0);
         wait_cyc($urandom_range(0, 5));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
